// File: rtl/game_timer_if.sv
// game_timer_if
// Command/status bundle between the game logic (master) and the game clock
// sequencer (slave).
//   commands (master -> slave): tick_in, start, pause, resume, solved, clear,
//                               penalty (only when TIMER_PENALTY_EN is defined)
//   status   (slave -> master): state[1:0], min_tens[2:0], min_ones[3:0],
//                               sec_tens[2:0], sec_ones[3:0], sec_pulse, time_up
// Optional feature macro: TIMER_PENALTY_EN
interface game_timer_if;
  logic       tick_in;
  logic       start;
  logic       pause;
  logic       resume;
  logic       solved;
  logic       clear;
`ifdef TIMER_PENALTY_EN
  logic       penalty;
`endif
  logic [1:0] state;
  logic [2:0] min_tens;
  logic [3:0] min_ones;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;
  logic       sec_pulse;
  logic       time_up;

`ifdef TIMER_PENALTY_EN
  modport master (
    output tick_in, start, pause, resume, solved, clear, penalty,
    input  state, min_tens, min_ones, sec_tens, sec_ones, sec_pulse, time_up
  );
  modport slave (
    input  tick_in, start, pause, resume, solved, clear, penalty,
    output state, min_tens, min_ones, sec_tens, sec_ones, sec_pulse, time_up
  );
`else
  modport master (
    output tick_in, start, pause, resume, solved, clear,
    input  state, min_tens, min_ones, sec_tens, sec_ones, sec_pulse, time_up
  );
  modport slave (
    input  tick_in, start, pause, resume, solved, clear,
    output state, min_tens, min_ones, sec_tens, sec_ones, sec_pulse, time_up
  );
`endif
endinterface

// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl
// Sudoku game clock: prescales tick_in by DIV into 1 s ticks and runs a BCD
// MM:SS elapsed-time counter, saturating at LIMIT_MIN:59 (time_up).
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   io_tmr   game_timer_if.slave (commands in, state/time/strobes out)
// Optional feature macro: TIMER_PENALTY_EN (penalty strobe adds PENALTY_SEC).
//
// state   | meaning
// S_IDLE  | cleared, waiting for start
// S_RUN   | counting seconds
// S_PAUSE | prescaler and time held
// S_DONE  | time frozen (solved, or limit reached with time_up=1)
module game_timer_ctrl #(
  parameter int unsigned DIV         = 100,
  parameter int unsigned LIMIT_MIN   = 59,
  parameter int unsigned PENALTY_SEC = 10
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  game_timer_if.slave io_tmr
);

  if (DIV < 2 || DIV > 255) begin : g_bad_div
    $error("game_timer_ctrl: DIV must be 2..255");
  end
  if (LIMIT_MIN > 59) begin : g_bad_limit
    $error("game_timer_ctrl: LIMIT_MIN must be 0..59");
  end
  if (PENALTY_SEC < 1 || PENALTY_SEC > 59) begin : g_bad_pen
    $error("game_timer_ctrl: PENALTY_SEC must be 1..59");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [7:0] PRESC_TOP = 8'(DIV - 1);
  localparam logic [2:0] LIM_TENS  = 3'(LIMIT_MIN / 10);
  localparam logic [3:0] LIM_ONES  = 4'(LIMIT_MIN % 10);
  localparam logic [6:0] LIM_MIN   = 7'(LIMIT_MIN);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_presc, w_presc_nxt;
  logic [2:0] r_min_tens, w_min_tens_nxt;
  logic [3:0] r_min_ones, w_min_ones_nxt;
  logic [2:0] r_sec_tens, w_sec_tens_nxt;
  logic [3:0] r_sec_ones, w_sec_ones_nxt;
  logic       r_sec_pulse, w_sec_pulse_nxt;
  logic       r_time_up, w_time_up_nxt;
  logic       w_zero;

  logic       w_tick_done;
  logic       w_pen;
  logic [4:0] w_so_sum;
  logic [3:0] w_st_sum;
  logic       w_c_so, w_c_st, w_c_mo, w_mt_ovf;
  logic [3:0] w_so_new, w_mo_new;
  logic [2:0] w_st_new, w_mt_new;
  logic [4:0] w_mo_sum;
  logic [3:0] w_mt_sum;
  logic [6:0] w_min_bin;
  logic       w_expire;

  assign w_tick_done = (r_presc == PRESC_TOP) && io_tmr.tick_in;

  // Seconds-digit addends: the 1 s tick always enters the ones column; the
  // penalty (when built in) is added as BCD so at most one minute carry results.
`ifdef TIMER_PENALTY_EN
  localparam logic [3:0] PEN_ONES = 4'(PENALTY_SEC % 10);
  localparam logic [3:0] PEN_TENS = 4'(PENALTY_SEC / 10);
  assign w_pen    = io_tmr.penalty;
  assign w_so_sum = {1'b0, r_sec_ones} + {1'b0, PEN_ONES & {4{w_pen}}}
                  + {4'b0, w_tick_done};
  assign w_st_sum = {1'b0, r_sec_tens} + (PEN_TENS & {4{w_pen}}) + {3'b0, w_c_so};
`else
  assign w_pen    = 1'b0;
  assign w_so_sum = {1'b0, r_sec_ones} + {4'b0, w_tick_done};
  assign w_st_sum = {1'b0, r_sec_tens} + {3'b0, w_c_so};
`endif

  always_comb begin
    w_c_so    = (w_so_sum >= 5'd10);
    w_so_new  = w_c_so ? 4'(w_so_sum - 5'd10) : w_so_sum[3:0];
    w_c_st    = (w_st_sum >= 4'd6);
    w_st_new  = w_c_st ? 3'(w_st_sum - 4'd6) : w_st_sum[2:0];
    w_mo_sum  = {1'b0, r_min_ones} + {4'b0, w_c_st};
    w_c_mo    = (w_mo_sum >= 5'd10);
    w_mo_new  = w_c_mo ? 4'd0 : w_mo_sum[3:0];
    w_mt_sum  = {1'b0, r_min_tens} + {3'b0, w_c_mo};
    w_mt_ovf  = (w_mt_sum > 4'd5);
    w_mt_new  = w_mt_sum[2:0];
    w_min_bin = {4'b0, w_mt_new} * 7'd10 + {3'b0, w_mo_new};
    w_expire  = w_mt_ovf || (w_min_bin > LIM_MIN);
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_presc_nxt     = r_presc;
    w_min_tens_nxt  = r_min_tens;
    w_min_ones_nxt  = r_min_ones;
    w_sec_tens_nxt  = r_sec_tens;
    w_sec_ones_nxt  = r_sec_ones;
    w_sec_pulse_nxt = 1'b0;
    w_time_up_nxt   = r_time_up;
    w_zero          = 1'b0;

    if (io_tmr.clear) begin
      w_state_nxt = S_IDLE;
      w_zero      = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_tmr.start) begin
            w_state_nxt = S_RUN;
            w_zero      = 1'b1;
          end
        end
        S_RUN: begin
          if (io_tmr.solved) begin
            w_state_nxt   = S_DONE;
            w_time_up_nxt = 1'b0;
          end else begin
            if (io_tmr.tick_in) w_presc_nxt = w_tick_done ? 8'd0 : r_presc + 8'd1;
            if (w_tick_done || w_pen) begin
              w_sec_pulse_nxt = w_tick_done;
              if (w_expire) begin
                w_state_nxt    = S_DONE;
                w_time_up_nxt  = 1'b1;
                w_min_tens_nxt = LIM_TENS;
                w_min_ones_nxt = LIM_ONES;
                w_sec_tens_nxt = 3'd5;
                w_sec_ones_nxt = 4'd9;
              end else begin
                w_min_tens_nxt = w_mt_new;
                w_min_ones_nxt = w_mo_new;
                w_sec_tens_nxt = w_st_new;
                w_sec_ones_nxt = w_so_new;
                if (io_tmr.pause) w_state_nxt = S_PAUSE;
              end
            end else if (io_tmr.pause) begin
              w_state_nxt = S_PAUSE;
            end
          end
        end
        S_PAUSE: begin
          if (io_tmr.solved) begin
            w_state_nxt   = S_DONE;
            w_time_up_nxt = 1'b0;
          end else if (io_tmr.resume) begin
            w_state_nxt = S_RUN;
          end
        end
        S_DONE: begin
          if (io_tmr.start) begin
            w_state_nxt = S_RUN;
            w_zero      = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    if (w_zero) begin
      w_presc_nxt    = 8'd0;
      w_min_tens_nxt = 3'd0;
      w_min_ones_nxt = 4'd0;
      w_sec_tens_nxt = 3'd0;
      w_sec_ones_nxt = 4'd0;
      w_time_up_nxt  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_presc     <= 8'd0;
      r_min_tens  <= 3'd0;
      r_min_ones  <= 4'd0;
      r_sec_tens  <= 3'd0;
      r_sec_ones  <= 4'd0;
      r_sec_pulse <= 1'b0;
      r_time_up   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_presc     <= w_presc_nxt;
      r_min_tens  <= w_min_tens_nxt;
      r_min_ones  <= w_min_ones_nxt;
      r_sec_tens  <= w_sec_tens_nxt;
      r_sec_ones  <= w_sec_ones_nxt;
      r_sec_pulse <= w_sec_pulse_nxt;
      r_time_up   <= w_time_up_nxt;
    end
  end

  assign io_tmr.state     = r_state;
  assign io_tmr.min_tens  = r_min_tens;
  assign io_tmr.min_ones  = r_min_ones;
  assign io_tmr.sec_tens  = r_sec_tens;
  assign io_tmr.sec_ones  = r_sec_ones;
  assign io_tmr.sec_pulse = r_sec_pulse;
  assign io_tmr.time_up   = r_time_up;

endmodule

// File: doc/game_timer_ctrl.md
Name: game_timer_ctrl

Overview:
- Sequences the Sudoku game clock: prescales the base tick strobe by DIV into 1 s ticks and runs a BCD MM:SS elapsed-time counter.
- A 4-state FSM (IDLE/RUN/PAUSE/DONE) controls it from player and game-logic commands.
- Sits between the board-level tick source and the display/scoring logic.
- Flags solve-complete or time-limit expiry.

Parameters:
- DIV, 100, base ticks per second; legal range 2..255; prescaler is 8 bits.
- LIMIT_MIN, 59, last legal minute value; legal range 0..59.
- PENALTY_SEC, 10, seconds added per penalty strobe; legal range 1..59; used only with TIMER_PENALTY_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tick_in  in  1  base tick, single-cycle strobe synchronous to clk
- start  in  1  begin a new game; sampled in IDLE or DONE
- pause  in  1  RUN -> PAUSE
- resume  in  1  PAUSE -> RUN
- solved  in  1  board-solved strobe from game logic
- clear  in  1  synchronous return to IDLE with zeroed time
- penalty  in  1  wrong-entry strobe; port present only with TIMER_PENALTY_EN
- state  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11
- min_tens  out  3  BCD minutes tens digit (0..5)
- min_ones  out  4  BCD minutes ones digit (0..9)
- sec_tens  out  3  BCD seconds tens digit (0..5)
- sec_ones  out  4  BCD seconds ones digit (0..9)
- sec_pulse  out  1  one-cycle strobe on each counted second
- time_up  out  1  high in DONE when the limit caused the exit; low otherwise

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all digits 0; prescaler 0.
  - sec_pulse=0, time_up=0.
  - Deassertion takes effect on the next clk edge.
- Command priority, evaluated each cycle: clear > solved > limit expiry > start/pause/resume.
- clear (any state): next cycle state=IDLE, digits 0, prescaler 0, time_up=0, sec_pulse=0.
- IDLE:
  - start -> RUN; digits and prescaler zeroed in the same edge.
  - All other inputs ignored.
- RUN:
  - tick_in increments the prescaler.
  - When prescaler==DIV-1 and tick_in=1: prescaler -> 0, time +1 s, sec_pulse=1 on the following cycle (registered, exactly 1 cycle).
  - pause -> PAUSE.
  - solved -> DONE with time frozen, time_up=0.
  - start and resume are ignored.
- PAUSE:
  - Prescaler and time hold; tick_in ignored.
  - resume -> RUN, continuing from the held prescaler value (no partial-second loss).
  - solved -> DONE.
- DONE:
  - Time frozen, outputs held.
  - start -> RUN with zeroed time, prescaler and time_up.
- Time arithmetic:
  - BCD with carries: sec_ones 9->0 carries into sec_tens; sec_tens 5->0 carries into minutes; min_ones 9->0 carries into min_tens.
  - Invalid BCD values are never produced.
- Limit expiry:
  - An increment that would exceed LIMIT_MIN:59 saturates the time at LIMIT_MIN:59.
  - State -> DONE with time_up=1; sec_pulse still fires for that second.
- Same-cycle events:
  - solved together with the expiring tick: solved wins; time frozen at the pre-tick value; time_up=0; no sec_pulse.
  - pause together with a completing tick: the second is counted, then PAUSE.
- Reset mid-operation: immediate return to reset values regardless of state.

Optional Feature:
- Macro: TIMER_PENALTY_EN.
- Defined:
  - penalty port exists.
  - penalty in RUN adds PENALTY_SEC seconds via BCD add with minute carry, subject to the same saturation/expiry rule (time_up=1).
  - If it coincides with a completing tick, both apply: +PENALTY_SEC+1 total.
  - Ignored outside RUN; no sec_pulse for penalty seconds.
- Undefined:
  - No penalty port, no adder logic.
  - Behaviour otherwise identical.

Test Plan:
- DIV=4: reset, start, 8 tick_in strobes -> time 00:02, two single-cycle sec_pulse strobes, state=RUN.
- DIV=4: run to 00:01 plus 2 ticks, pause, 10 ticks, resume, 2 ticks -> time 00:02 (held prescaler honoured), no change during PAUSE.
- DIV=2, LIMIT_MIN=1, from 01:58: 4 ticks -> 01:59 then DONE, time_up=1, time stays 01:59; further ticks ignored; start -> RUN at 00:00, time_up=0.
- Carry check: at 09:59, one second -> 10:00; at 00:09 -> 00:10.
- Same cycle: solved with the limit-expiring tick -> DONE, time_up=0, time unchanged. clear with solved -> IDLE, 00:00. rst low mid-RUN -> all outputs at reset values asynchronously.
- TIMER_PENALTY_EN, PENALTY_SEC=10: at 00:55, penalty -> 01:05; at 00:55, penalty with a completing tick -> 01:06; penalty in PAUSE -> no change.
